// File: rtl/sd_cmd_sequencer_if.sv
// Command-sequencer bundle: enqueue port, queue status, command-block handshake
// and completion/error reporting. The sequencer is the master side.
interface sd_cmd_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 push;
    logic [5:0]           push_index;
    logic [31:0]          push_argument;
    logic                 push_no_response;
    logic                 full;
    logic                 empty;
    logic                 overflow;
    logic                 new_command;
    logic [5:0]           cmd_index;
    logic [31:0]          cmd_argument;
    logic                 no_response;
    logic                 timeout_enable;
    logic                 ack_response;
    logic                 ack_command_complete;
    logic                 done;
    logic                 timeout_error;
    logic [CNT_WIDTH-1:0] completed_count;

    modport master (
        input  push, push_index, push_argument, push_no_response,
        input  ack_response, ack_command_complete,
        output full, empty, overflow,
        output new_command, cmd_index, cmd_argument, no_response, timeout_enable,
        output done, timeout_error, completed_count
    );

    modport slave (
        output push, push_index, push_argument, push_no_response,
        output ack_response, ack_command_complete,
        input  full, empty, overflow,
        input  new_command, cmd_index, cmd_argument, no_response, timeout_enable,
        input  done, timeout_error, completed_count
    );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// SD host command sequencer: queues commands in a small FIFO and issues them one
// at a time to the command block, with a per-command timeout.
module sd_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic               clock,
    input  logic               reset,
    sd_cmd_sequencer_if.master bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_ACTIVE        = 3'd1,
        ST_WAIT_COMPLETE = 3'd2,
        ST_DONE          = 3'd3,
        ST_ERROR         = 3'd4
    } state_t;

    typedef struct packed {
        logic        no_resp;
        logic [5:0]  index;
        logic [31:0] argument;
    } entry_t;

    entry_t               mem_r [DEPTH];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    state_t               state_r;
    logic [TW-1:0]        timer_r;
    logic                 full_r;
    logic                 empty_r;
    logic                 overflow_r;
    logic                 new_command_r;
    logic [5:0]           cmd_index_r;
    logic [31:0]          cmd_argument_r;
    logic                 no_response_r;
    logic                 done_r;
    logic                 timeout_error_r;
    logic [CNT_WIDTH-1:0] completed_count_r;

    state_t               state_nxt_s;
    logic                 push_ok_s;
    logic                 pop_s;
    logic                 busy_s;
    logic                 timer_last_s;
    logic [PW-1:0]        wr_ptr_nxt_s;
    logic [PW-1:0]        rd_ptr_nxt_s;
    logic [PW-1:0]        level_nxt_s;
    entry_t               head_s;

    // A push into a full queue is dropped even if a pop frees a slot on the same edge.
    assign push_ok_s    = bus.push && !full_r;
    assign pop_s        = (state_r == ST_IDLE) && !empty_r;
    assign busy_s       = (state_r == ST_ACTIVE) || (state_r == ST_WAIT_COMPLETE);
    assign timer_last_s = (timer_r == TIMER_LAST);
    assign wr_ptr_nxt_s = push_ok_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
    assign rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
    assign level_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
    assign head_s       = mem_r[rd_ptr_r[AW-1:0]];

    // Next-state decode; completion takes priority over the timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (bus.ack_command_complete) begin
                    state_nxt_s = ST_DONE;
                end else if (timer_last_s) begin
                    state_nxt_s = ST_ERROR;
                end else if (bus.ack_response && !no_response_r) begin
                    state_nxt_s = ST_WAIT_COMPLETE;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_WAIT_COMPLETE: begin
                if (bus.ack_command_complete) begin
                    state_nxt_s = ST_DONE;
                end else if (timer_last_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_WAIT_COMPLETE;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            ST_ERROR: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Queue pointers, FSM state, timer and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r          <= '0;
            rd_ptr_r          <= '0;
            state_r           <= ST_IDLE;
            timer_r           <= '0;
            full_r            <= 1'b0;
            empty_r           <= 1'b1;
            overflow_r        <= 1'b0;
            new_command_r     <= 1'b0;
            cmd_index_r       <= 6'd0;
            cmd_argument_r    <= 32'd0;
            no_response_r     <= 1'b0;
            done_r            <= 1'b0;
            timeout_error_r   <= 1'b0;
            completed_count_r <= '0;
        end else begin
            wr_ptr_r        <= wr_ptr_nxt_s;
            rd_ptr_r        <= rd_ptr_nxt_s;
            full_r          <= (level_nxt_s == PW'(DEPTH));
            empty_r         <= (level_nxt_s == PW'(0));
            overflow_r      <= overflow_r | (bus.push & full_r);
            state_r         <= state_nxt_s;
            new_command_r   <= (state_nxt_s == ST_ACTIVE) || (state_nxt_s == ST_WAIT_COMPLETE);
            done_r          <= (state_nxt_s == ST_DONE);
            timeout_error_r <= (state_nxt_s == ST_ERROR);
            if (state_nxt_s == ST_DONE) begin
                completed_count_r <= completed_count_r + CNT_WIDTH'(1);
            end
            if (pop_s) begin
                cmd_index_r    <= head_s.index;
                cmd_argument_r <= head_s.argument;
                no_response_r  <= head_s.no_resp;
                timer_r        <= '0;
            end else if (busy_s && (timer_r != TIMER_MAX)) begin
                timer_r <= timer_r + TW'(1);
            end
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= '{no_resp:  bus.push_no_response,
                                        index:    bus.push_index,
                                        argument: bus.push_argument};
        end
    end

    assign bus.full            = full_r;
    assign bus.empty           = empty_r;
    assign bus.overflow        = overflow_r;
    assign bus.new_command     = new_command_r;
    assign bus.timeout_enable  = new_command_r;
    assign bus.cmd_index       = cmd_index_r;
    assign bus.cmd_argument    = cmd_argument_r;
    assign bus.no_response     = no_response_r;
    assign bus.done            = done_r;
    assign bus.timeout_error   = timeout_error_r;
    assign bus.completed_count = completed_count_r;

endmodule
